// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder: streaming inverse of a complex sum/difference stage.
// Accepts S then D over two input beats, emits A = (S+D)/2 then B = (S-D)/2
// over two output beats. Division is floor division (arithmetic shift). An odd
// sum means S and D cannot come from integer A and B, and is flagged.
module sum_diff_decoder #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_re,
  input  logic [n-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_re,
  output logic [n-1:0] out_im,
  output logic         out_sel,
  output logic         parity_err,
  output logic [7:0]   pair_cnt
);

  typedef enum logic [1:0] {
    StGetS,
    StGetD,
    StPutA,
    StPutB
  } state_e;

  state_e state_q, state_d;

  // Held S operand, pending B result, and the currently presented output beat.
  logic [n-1:0] s_re_q, s_im_q;
  logic [n-1:0] b_re_q, b_im_q;
  logic [n-1:0] out_re_q, out_im_q;
  logic         parity_q;
  logic [7:0]   pair_cnt_q;

  // One extra bit of headroom so S+D and S-D never wrap.
  logic signed [n:0] sr, si, dr, di;

  logic s_fire, d_fire, a_fire, b_fire;

  // Sign-extended sum and difference of the held S with the incoming D.
  always_comb begin
    sr = $signed({s_re_q[n-1], s_re_q}) + $signed({in_re[n-1], in_re});
    si = $signed({s_im_q[n-1], s_im_q}) + $signed({in_im[n-1], in_im});
    dr = $signed({s_re_q[n-1], s_re_q}) - $signed({in_re[n-1], in_re});
    di = $signed({s_im_q[n-1], s_im_q}) - $signed({in_im[n-1], in_im});
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sel   = 1'b0;
    s_fire    = 1'b0;
    d_fire    = 1'b0;
    a_fire    = 1'b0;
    b_fire    = 1'b0;
    unique case (state_q)
      StGetS: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_fire  = 1'b1;
          state_d = StGetD;
        end
      end
      StGetD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          d_fire  = 1'b1;
          state_d = StPutA;
        end
      end
      StPutA: begin
        out_valid = 1'b1;
        if (out_ready) begin
          a_fire  = 1'b1;
          state_d = StPutB;
        end
      end
      StPutB: begin
        out_valid = 1'b1;
        out_sel   = 1'b1;
        if (out_ready) begin
          b_fire  = 1'b1;
          state_d = StGetS;
        end
      end
      default: state_d = StGetS;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGetS;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, result registers and delivered-pair counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_re_q     <= '0;
      s_im_q     <= '0;
      b_re_q     <= '0;
      b_im_q     <= '0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      parity_q   <= 1'b0;
      pair_cnt_q <= 8'd0;
    end else begin
      if (s_fire) begin
        s_re_q <= in_re;
        s_im_q <= in_im;
      end
      if (d_fire) begin
        // Bits [n:1] are the arithmetic shift right by one, truncated to n bits.
        out_re_q <= sr[n:1];
        out_im_q <= si[n:1];
        b_re_q   <= dr[n:1];
        b_im_q   <= di[n:1];
        // sr[0] == dr[0], so the sum LSBs alone decide parity.
        parity_q <= sr[0] | si[0];
      end
      if (a_fire) begin
        out_re_q <= b_re_q;
        out_im_q <= b_im_q;
      end
      if (b_fire) begin
        pair_cnt_q <= pair_cnt_q + 8'd1;
      end
    end
  end

  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign parity_err = parity_q;
  assign pair_cnt   = pair_cnt_q;

endmodule

// File: doc/sum_diff_decoder.md
# sum_diff_decoder

Streaming inverse of the complex sum/difference stage. Each input pair is a sum S = A+B followed by a difference D = A−B, presented over two beats. The block recovers A = (S+D)/2 and B = (S−D)/2 and emits them as two output beats under a valid/ready handshake. It sits downstream of the butterfly add/sub datapath, for example in round-trip checking or in inverse-transform paths, and flags any pair whose sum/difference parity cannot come from integer A and B.

## Interface
- n, 4, width of each signed real/imag component (n ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input beat offered
- in_ready  output  1  block accepts input beat this cycle
- in_re  input  n  signed real part; beat 0 = S, beat 1 = D
- in_im  input  n  signed imag part; beat 0 = S, beat 1 = D
- out_valid  output  1  output beat offered
- out_ready  input  1  downstream accepts output beat
- out_re  output  n  signed real part; beat 0 = A, beat 1 = B
- out_im  output  n  signed imag part; beat 0 = A, beat 1 = B
- out_sel  output  1  0 = A beat, 1 = B beat
- parity_err  output  1  odd sum detected for the current pair; valid with out_valid
- pair_cnt  output  8  number of pairs fully delivered; wraps 255→0

## Operation
- FSM has four states: GET_S, GET_D, PUT_A, PUT_B. Reset state is GET_S.
- **GET_S**
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: register in_re/in_im as S, then go to GET_D.
- **GET_D**
  - in_ready=1, out_valid=0.
  - On the handshake: compute in (n+1)-bit signed arithmetic:
    - sr=S_re+D_re, si=S_im+D_im
    - dr=S_re−D_re, di=S_im−D_im
  - Register A=(sr>>>1, si>>>1) and B=(dr>>>1, di>>>1), each truncated to n bits.
  - Register parity_err = sr[0] | si[0], then go to PUT_A.
- **Arithmetic**
  - Arithmetic shift gives floor division.
  - For any n-bit S and D, results lie in [−2^(n−1), 2^(n−1)−1], so no overflow or saturation logic is needed.
  - sr[0] equals dr[0], so checking the sum LSB is sufficient.
- **PUT_A**
  - out_valid=1, out_sel=0, out_re/out_im=A, in_ready=0.
  - On out_ready: go to PUT_B.
- **PUT_B**
  - out_valid=1, out_sel=1, out_re/out_im=B, in_ready=0.
  - On out_ready: pair_cnt+1, go to GET_S.
- **Stall rules**
  - While out_valid=1 and out_ready=0, out_re, out_im, out_sel and parity_err hold stable.
  - in_ready=0 in both PUT states, so input and output handshakes never coincide.
- parity_err stays asserted for both beats of an erroneous pair. The A and B values are still delivered using floor arithmetic.
- **Reset**
  - rst overrides all other inputs.
  - Reset values: state=GET_S, in_ready=1 (combinational from state), out_valid=0, out_sel=0, out_re=0, out_im=0, parity_err=0, pair_cnt=0.
  - Reset in GET_D discards a held S. Reset in PUT_A or PUT_B drops the pending beats, and pair_cnt does not increment.
- in_valid is ignored in PUT states. out_ready is ignored in GET states.

## Timing
- All state changes happen on the rising edge of clk.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.
- Latency: if D is accepted at edge t, out_valid=1 with the A beat from edge t.
  - With out_ready held high, A is taken at edge t+1 and B at edge t+2.
  - in_ready rises after edge t+2.
- Throughput: one pair per 4 cycles with no backpressure.
- pair_cnt updates on the edge that accepts the B beat.

## Test plan
- **Basic pair, n=4:** S=(4,0), D=(2,−4).
  - Beats: A=(3,−2), out_sel=0, then B=(1,2), out_sel=1.
  - parity_err=0, pair_cnt 0→1.
- **Extremes:** S=(−8,7), D=(−8,−7).
  - A=(−8,0), B=(0,7), parity_err=0.
- **Odd parity:** S=(7,0), D=(−8,0).
  - sr=−1, so A=(−1,0) and B=(7,0), with parity_err=1 on both beats.
- **Backpressure:** out_ready=0 for 5 cycles during PUT_A, then 3 cycles during PUT_B.
  - Outputs hold stable and in_ready stays 0.
  - Exactly 2 output handshakes occur and pair_cnt increments once.
- **Reset mid-pair:**
  - Accept S, assert rst for 1 cycle, then send a new pair S=(2,2), D=(0,0).
  - Outputs A=(1,1), B=(1,1); the old S has no effect; pair_cnt=1.
- **Counter wrap:** 256 back-to-back pairs with random S/D checked against a reference model.
  - pair_cnt returns to 0.
  - Each pair takes exactly 4 cycles with out_ready=1.
